// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, FSM state encoding and parity helper.
// Used by both the transmitter and the matching receiver.
package uart_pkg;

   localparam int unsigned PAR_NONE = 0;
   localparam int unsigned PAR_EVEN = 1;
   localparam int unsigned PAR_ODD  = 2;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } uart_state_e;

   // Callers zero-extend narrower words; padding zeros do not change the XOR.
   function automatic logic parity_calc(input logic [8:0] data, input int unsigned mode);
      return (mode == PAR_ODD) ? ~(^data) : ^data;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Per-bit down-counter: reloaded at every bit boundary, tick on the last cycle of a bit.
module uart_bit_timer #(
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic enable,
   input  logic load,
   output logic tick
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= RELOAD;
      end else if (enable && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign tick = enable && (cnt_q == '0);

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter with valid/ready input and a one-entry holding buffer,
// so back-to-back frames leave with no idle gap on uart_txd.
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ       = 100000000,
   parameter int unsigned BIT_RATE     = 9600,
   parameter int unsigned CLKS_PER_BIT = CLK_HZ / BIT_RATE,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned PARITY       = 0,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 tx_valid,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_ready,
   output logic                 uart_txd,
   output logic                 tx_busy,
   output logic                 tx_done
);

   if (CLKS_PER_BIT < 2) begin : g_bad_cpb
      $error("uart_tx_frame: CLKS_PER_BIT must be >= 2");
   end
   if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_db
      $error("uart_tx_frame: DATA_BITS must be in 5..9");
   end
   if (PARITY > PAR_ODD) begin : g_bad_par
      $error("uart_tx_frame: PARITY must be 0, 1 or 2");
   end
   if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_sb
      $error("uart_tx_frame: STOP_BITS must be 1 or 2");
   end

   localparam int unsigned IW = $clog2(DATA_BITS + 1);
   localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
   localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

   uart_state_e          state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic                 par_q, par_d;
   logic                 txd_q, txd_d;
   logic                 done_q, done_d;
   logic                 hold_valid_q;
   logic [DATA_BITS-1:0] hold_data_q;
   logic                 hold_clr, accept, start_frame, timer_load, tick;

   assign accept   = tx_valid && tx_ready;
   assign tx_ready = !hold_valid_q;
   assign uart_txd = txd_q;
   assign tx_busy  = (state_q != StIdle);
   assign tx_done  = done_q;

   uart_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_timer (
      .clk    (clk),
      .reset_n(reset_n),
      .enable (tx_busy),
      .load   (timer_load),
      .tick   (tick)
   );

   // Accept needs an empty buffer and load needs a full one, so they never collide.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_valid_q <= 1'b0;
         hold_data_q  <= '0;
      end else begin
         if (hold_clr) begin
            hold_valid_q <= 1'b0;
         end else if (accept) begin
            hold_valid_q <= 1'b1;
         end
         if (accept) begin
            hold_data_q <= tx_data;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      idx_d       = idx_q;
      par_d       = par_q;
      txd_d       = txd_q;
      done_d      = 1'b0;
      hold_clr    = 1'b0;
      timer_load  = 1'b0;
      start_frame = 1'b0;
      unique case (state_q)
         StIdle: begin
            txd_d       = 1'b1;
            start_frame = hold_valid_q;
         end
         StStart: begin
            if (tick) begin
               state_d    = StData;
               txd_d      = shift_q[0];
               shift_d    = shift_q >> 1;
               idx_d      = '0;
               timer_load = 1'b1;
            end
         end
         StData: begin
            if (tick) begin
               timer_load = 1'b1;
               if (idx_q == LAST_DATA) begin
                  idx_d = '0;
                  if (PARITY != PAR_NONE) begin
                     state_d = StParity;
                     txd_d   = par_q;
                  end else begin
                     state_d = StStop;
                     txd_d   = 1'b1;
                  end
               end else begin
                  idx_d   = idx_q + 1'b1;
                  txd_d   = shift_q[0];
                  shift_d = shift_q >> 1;
               end
            end
         end
         StParity: begin
            if (tick) begin
               state_d    = StStop;
               txd_d      = 1'b1;
               idx_d      = '0;
               timer_load = 1'b1;
            end
         end
         StStop: begin
            if (tick) begin
               if (idx_q == LAST_STOP) begin
                  done_d = 1'b1;
                  if (hold_valid_q) begin
                     start_frame = 1'b1;
                  end else begin
                     state_d = StIdle;
                     txd_d   = 1'b1;
                  end
               end else begin
                  idx_d      = idx_q + 1'b1;
                  timer_load = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
      // Frame load is shared by IDLE and the final stop boundary (back-to-back case).
      if (start_frame) begin
         state_d    = StStart;
         txd_d      = 1'b0;
         shift_d    = hold_data_q;
         par_d      = parity_calc(9'(hold_data_q), PARITY);
         idx_d      = '0;
         hold_clr   = 1'b1;
         timer_load = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         shift_q <= '0;
         idx_q   <= '0;
         par_q   <= 1'b0;
         txd_q   <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         par_q   <= par_d;
         txd_q   <= txd_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: five configurations side by side, table vectors,
// hand-written back-to-back and reset sequences, and random words against a frame model.
module tb_uart_tx_frame;

   localparam int CPB  = 4;
   localparam int NI   = 5;
   localparam int MAXC = 128;
   localparam int CFG_DB  [NI] = '{8, 7, 7, 8, 9};
   localparam int CFG_PAR [NI] = '{0, 1, 2, 2, 0};
   localparam int CFG_SB  [NI] = '{1, 1, 1, 2, 1};

   logic          clk = 1'b0;
   logic          reset_n;
   logic [NI-1:0] valid, ready, txd, busy, done;
   logic [8:0]    data [NI];

   always #5 clk = ~clk;

   uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
      .clk(clk), .reset_n(reset_n), .tx_valid(valid[0]), .tx_data(data[0][7:0]),
      .tx_ready(ready[0]), .uart_txd(txd[0]), .tx_busy(busy[0]), .tx_done(done[0]));
   uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) u_7e1 (
      .clk(clk), .reset_n(reset_n), .tx_valid(valid[1]), .tx_data(data[1][6:0]),
      .tx_ready(ready[1]), .uart_txd(txd[1]), .tx_busy(busy[1]), .tx_done(done[1]));
   uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_7o1 (
      .clk(clk), .reset_n(reset_n), .tx_valid(valid[2]), .tx_data(data[2][6:0]),
      .tx_ready(ready[2]), .uart_txd(txd[2]), .tx_busy(busy[2]), .tx_done(done[2]));
   uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u_8o2 (
      .clk(clk), .reset_n(reset_n), .tx_valid(valid[3]), .tx_data(data[3][7:0]),
      .tx_ready(ready[3]), .uart_txd(txd[3]), .tx_busy(busy[3]), .tx_done(done[3]));
   uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(9), .PARITY(0), .STOP_BITS(1)) u_9n1 (
      .clk(clk), .reset_n(reset_n), .tx_valid(valid[4]), .tx_data(data[4][8:0]),
      .tx_ready(ready[4]), .uart_txd(txd[4]), .tx_busy(busy[4]), .tx_done(done[4]));

   typedef struct {
      int         inst;
      logic [8:0] word;
      logic [15:0] bits;   // expected line level per bit period, first bit in bit 0
      int         nbits;
   } vec_t;

   int   n_pass = 0;
   int   n_total = 0;
   logic cap_txd [MAXC];
   logic cap_busy [MAXC];
   logic cap_done [MAXC];
   logic cap_ready [MAXC];
   logic exp_q [$];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
   endtask

   // Frame model: start 0, data LSB first, parity from the count of ones, then stop ones.
   function automatic logic [15:0] model_bits(input int inst, input logic [8:0] word,
                                             output int nbits);
      logic [15:0] b = '0;
      int n = 1;
      int ones = 0;
      for (int i = 0; i < CFG_DB[inst]; i++) begin
         b[n] = word[i];
         ones += int'(word[i]);
         n++;
      end
      if (CFG_PAR[inst] == 1) begin
         b[n] = (ones % 2) == 1;
         n++;
      end else if (CFG_PAR[inst] == 2) begin
         b[n] = (ones % 2) == 0;
         n++;
      end
      for (int s = 0; s < CFG_SB[inst]; s++) begin
         b[n] = 1'b1;
         n++;
      end
      nbits = n;
      return b;
   endfunction

   task automatic push_frame(input logic [15:0] bits, input int nbits);
      for (int b = 0; b < nbits; b++)
         for (int k = 0; k < CPB; k++) exp_q.push_back(bits[b]);
   endtask

   task automatic start_frame(input int inst, input logic [8:0] word);
      @(negedge clk);
      valid[inst] = 1'b1;
      data[inst]  = word;
      @(posedge clk);
      #1;
      valid[inst] = 1'b0;
      data[inst]  = 9'($urandom);
      chk("ready_low_after_accept", 32'(ready[inst]), 0);
   endtask

   // Sample c is taken 1ns after the c-th edge following the accept edge.
   task automatic capture(input int inst, input int ncyc, input int offer_at,
                          input logic [8:0] offer_word);
      for (int c = 0; c < ncyc; c++) begin
         @(posedge clk);
         #1;
         cap_txd[c]   = txd[inst];
         cap_busy[c]  = busy[inst];
         cap_done[c]  = done[inst];
         cap_ready[c] = ready[inst];
         if (offer_at >= 0 && c == offer_at) begin
            valid[inst] = 1'b1;
            data[inst]  = offer_word;
         end else if (offer_at >= 0 && c == offer_at + 1) begin
            valid[inst] = 1'b0;
            data[inst]  = 9'($urandom);
         end
      end
   endtask

   task automatic wave_check(input string name, input int ncyc);
      int bad = 0;
      int first = -1;
      logic e;
      for (int c = 0; c < ncyc; c++) begin
         e = (c < exp_q.size()) ? exp_q[c] : 1'b1;
         if (cap_txd[c] !== e) begin
            bad++;
            if (first < 0) first = c;
         end
      end
      chk($sformatf("%s_wave_bad_cycles(first=%0d)", name, first), bad, 0);
   endtask

   task automatic done_busy_check(input string name, input int ncyc, input int busy_exp,
                                  input int ndone_exp, input int first_done_exp);
      int nb = 0;
      int nd = 0;
      int fd = -1;
      for (int c = 0; c < ncyc; c++) begin
         if (cap_busy[c] === 1'b1) nb++;
         if (cap_done[c] === 1'b1) begin
            nd++;
            if (fd < 0) fd = c;
         end
      end
      chk({name, "_busy_cycles"}, nb, busy_exp);
      chk({name, "_done_count"}, nd, ndone_exp);
      if (ndone_exp > 0) chk({name, "_done_cycle"}, fd, first_done_exp);
   endtask

   task automatic run_single(input string name, input int inst, input logic [8:0] word,
                             input logic [15:0] bits, input int nbits);
      int len = nbits * CPB;
      start_frame(inst, word);
      capture(inst, len + 2, -1, '0);
      exp_q.delete();
      push_frame(bits, nbits);
      wave_check(name, len + 2);
      done_busy_check(name, len + 2, len, 1, len);
      chk({name, "_ready_after"}, 32'(cap_ready[len]), 1);
   endtask

   vec_t vecs [5];

   initial begin
      logic [15:0] mb;
      int nb;
      logic [8:0] w;

      vecs[0] = '{0, 9'h0A5, 16'h034A, 10};
      vecs[1] = '{1, 9'h041, 16'h0282, 10};
      vecs[2] = '{2, 9'h041, 16'h0382, 10};
      vecs[3] = '{3, 9'h000, 16'h0E00, 12};
      vecs[4] = '{4, 9'h1FF, 16'h07FE, 11};

      reset_n = 1'b0;
      valid   = '0;
      for (int i = 0; i < NI; i++) data[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_txd", 32'(txd), 32'h1F);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_done", 32'(done), 0);
      chk("reset_ready", 32'(ready), 32'h1F);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(posedge clk);

      for (int i = 0; i < 5; i++)
         run_single($sformatf("vec%0d", i), vecs[i].inst, vecs[i].word, vecs[i].bits,
                    vecs[i].nbits);

      // Back-to-back: 0x55 in flight, 0xAA offered at sample 5 and queued.
      start_frame(0, 9'h055);
      capture(0, 82, 5, 9'h0AA);
      exp_q.delete();
      push_frame(16'h02AA, 10);
      push_frame(16'h0354, 10);
      wave_check("b2b", 82);
      done_busy_check("b2b", 82, 80, 2, 40);
      chk("b2b_second_done", 32'(cap_done[80]), 1);
      chk("b2b_ready_queued", 32'(cap_ready[39]), 0);
      chk("b2b_ready_after_load", 32'(cap_ready[40]), 1);

      // Reset during data bit 3 with a word queued.
      start_frame(0, 9'h05A);
      capture(0, 18, 2, 9'h081);
      #2;
      reset_n = 1'b0;
      #1;
      chk("midreset_txd", 32'(txd[0]), 1);
      chk("midreset_busy", 32'(busy[0]), 0);
      chk("midreset_done", 32'(done[0]), 0);
      chk("midreset_ready", 32'(ready[0]), 1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      capture(0, 60, -1, '0);
      exp_q.delete();
      wave_check("after_reset_idle", 60);
      done_busy_check("after_reset_idle", 60, 0, 0, 0);
      run_single("post_reset_3C", 0, 9'h03C, 16'h0278, 10);

      for (int inst = 0; inst < NI; inst++) begin
         for (int r = 0; r < 6; r++) begin
            w  = 9'($urandom_range(0, (1 << CFG_DB[inst]) - 1));
            mb = model_bits(inst, w, nb);
            run_single($sformatf("rand_i%0d_w%0h", inst, w), inst, w, mb, nb);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
